// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 8N1 oversampling UART receiver; define UART_RX_MAJORITY_EN for 2-of-3 bit voting
module uart_rx_deserializer #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DIVISOR    = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_available,
    output logic       o_frame_error,
    output logic       o_busy
);

    localparam int DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int TCK_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
    localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(OVERSAMPLE - 1);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [TCK_W-1:0] VOTE_FIRST = TCK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCK_W-1:0] VOTE_MID   = TCK_W'(OVERSAMPLE / 2);
    localparam logic [TCK_W-1:0] SAMPLE_IDX = TCK_W'(OVERSAMPLE / 2 + 1);
`else
    localparam logic [TCK_W-1:0] SAMPLE_IDX = TCK_W'(OVERSAMPLE / 2);
`endif

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
        S_STOP       = 3'd3,
        S_BREAK_WAIT = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_rx_meta;
    logic              r_rx_s;
    logic              r_rx_prev;
    logic [1:0]        r_valid_sr;
    logic              r_armed;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [TCK_W-1:0]  r_tick_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [7:0]        r_byte;
    logic              r_byte_available;
    logic              r_frame_error;

    logic              w_fall;
    logic              w_tick;
    logic              w_sample;
    logic              w_bit_end;
    logic              w_bit;

    // Two-flop synchroniser plus edge history; r_armed stays low until the
    // real line has been seen high after reset, so a frame cut by reset is ignored
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_valid_sr <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            r_rx_meta  <= i_rx;
            r_rx_s     <= r_rx_meta;
            r_rx_prev  <= r_rx_s;
            r_valid_sr <= {r_valid_sr[0], 1'b1};
            if (r_valid_sr[1] && r_rx_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_fall = r_armed && r_rx_prev && !r_rx_s;

    // Sample-tick divider, parked at zero in IDLE so ticks are phased to the start edge
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_div_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign w_tick = (r_state != S_IDLE) && (r_div_cnt == DIV_LAST);

    // Position of the current tick within the bit period, wrapping every bit
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_tick_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            if (r_tick_cnt == TCK_LAST) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    assign w_sample  = w_tick && (r_tick_cnt == SAMPLE_IDX);
    assign w_bit_end = w_tick && (r_tick_cnt == TCK_LAST);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_vote;

    // Capture the two samples preceding the decision tick for the 2-of-3 vote
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_vote <= 2'b00;
        end else if (w_tick && (r_tick_cnt == VOTE_FIRST)) begin
            r_vote[0] <= r_rx_s;
        end else if (w_tick && (r_tick_cnt == VOTE_MID)) begin
            r_vote[1] <= r_rx_s;
        end
    end

    assign w_bit = (r_vote[0] & r_vote[1]) | (r_vote[0] & r_rx_s) | (r_vote[1] & r_rx_s);
`else
    assign w_bit = r_rx_s;
`endif

    // Frame sequencer with registered byte and strobe outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state          <= S_IDLE;
            r_bit_cnt        <= 3'd0;
            r_shift          <= 8'h00;
            r_byte           <= 8'h00;
            r_byte_available <= 1'b0;
            r_frame_error    <= 1'b0;
        end else begin
            r_byte_available <= 1'b0;
            r_frame_error    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= 3'd0;
                    if (w_fall) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_sample && w_bit) begin
                        r_state <= S_IDLE;
                    end else if (w_bit_end) begin
                        r_bit_cnt <= 3'd0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_shift <= {w_bit, r_shift[7:1]};
                    end
                    if (w_bit_end) begin
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    // Leave at the stop-bit sample so a back-to-back start edge is not missed
                    if (w_sample) begin
                        if (w_bit) begin
                            r_byte           <= r_shift;
                            r_byte_available <= 1'b1;
                            r_state          <= S_IDLE;
                        end else begin
                            r_frame_error <= 1'b1;
                            r_state       <= S_BREAK_WAIT;
                        end
                    end
                end
                S_BREAK_WAIT: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_byte           = r_byte;
    assign o_byte_available = r_byte_available;
    assign o_frame_error    = r_frame_error;
    assign o_busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - directed and random frames checked against a line-level receive model
module tb_uart_rx_deserializer;

    localparam int CLOCK_FREQ = 1600000;
    localparam int BAUD_RATE  = 10000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = CLOCK_FREQ / BAUD_RATE;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] dut_byte;
    logic       dut_avail;
    logic       dut_fe;
    logic       dut_busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int         fe_count   = 0;
    logic       prev_avail = 1'b0;
    logic [7:0] last_good  = 8'h00;

    uart_rx_deserializer #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_rx             (rx),
        .o_byte           (dut_byte),
        .o_byte_available (dut_avail),
        .o_frame_error    (dut_fe),
        .o_busy           (dut_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame; optionally a 1-clk low pulse at the middle of data bit 1
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit glitch_b1);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (glitch_b1 && i == 2) begin
                step(BIT_CLKS / 2 + 10);
                rx = 1'b0;
                step(1);
                rx = bits[i];
                step(BIT_CLKS / 2 - 11);
            end else begin
                step(BIT_CLKS);
            end
        end
    endtask

    // Model: a frame with a valid stop bit yields its data byte, a low stop bit yields an error
    task automatic expect_frame(input logic [7:0] d, input logic stop_bit);
        if (stop_bit) begin
            exp_q.push_back(d);
            last_good = d;
        end
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (dut_avail || dut_fe) begin
            check("strobes_exclusive", 32'(dut_avail & dut_fe), 32'd0);
        end
        if (dut_avail) begin
            check("avail_spacing", 32'(prev_avail), 32'd0);
            obs_q.push_back(dut_byte);
        end
        if (dut_fe) begin
            fe_count++;
        end
        prev_avail = dut_avail;
    end

    initial begin
        string      msg;
        logic [7:0] d;
        logic [7:0] glitch_exp;

        rst = 1'b0;
        rx  = 1'b1;
        step(5);
        check("reset_byte", 32'(dut_byte), 32'h00);
        check("reset_avail", 32'(dut_avail), 32'd0);
        check("reset_fe", 32'(dut_fe), 32'd0);
        check("reset_busy", 32'(dut_busy), 32'd0);
        rst = 1'b1;
        step(20);

        send_frame(8'h4C, 1'b1, 1'b0);
        expect_frame(8'h4C, 1'b1);
        check("single_busy_idle", 32'(dut_busy), 32'd0);
        check("single_byte_held", 32'(dut_byte), 32'h4C);
        compare_stream("single");
        step(50);

        msg = "L00000001";
        for (int i = 0; i < msg.len(); i++) begin
            send_frame(msg[i], 1'b1, 1'b0);
            expect_frame(msg[i], 1'b1);
        end
        step(20);
        compare_stream("b2b");
        check("b2b_no_fe", 32'(fe_count), 32'd0);

        rx = 1'b0;
        step(10);
        check("false_start_busy", 32'(dut_busy), 32'd1);
        step(30);
        rx = 1'b1;
        step(BIT_CLKS * 2);
        check("false_start_idle", 32'(dut_busy), 32'd0);
        check("false_start_fe", 32'(fe_count), 32'd0);
        compare_stream("false_start");

        send_frame(8'h55, 1'b0, 1'b0);
        expect_frame(8'h55, 1'b0);
        rx = 1'b0;
        step(3000);
        check("break_fe_count", 32'(fe_count), 32'd1);
        check("break_byte_kept", 32'(dut_byte), 32'(last_good));
        check("break_busy", 32'(dut_busy), 32'd1);
        rx = 1'b1;
        step(20);
        check("break_release_idle", 32'(dut_busy), 32'd0);
        send_frame(8'hA3, 1'b1, 1'b0);
        expect_frame(8'hA3, 1'b1);
        step(20);
        compare_stream("after_break");
        check("after_break_fe", 32'(fe_count), 32'd1);

        rx = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            step(BIT_CLKS);
        end
        step(BIT_CLKS / 2);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_byte", 32'(dut_byte), 32'h00);
        check("midreset_avail", 32'(dut_avail), 32'd0);
        check("midreset_fe", 32'(dut_fe), 32'd0);
        check("midreset_busy", 32'(dut_busy), 32'd0);
        step(10);
        rst = 1'b1;
        last_good = 8'h00;
        step(BIT_CLKS * 5);
        send_frame(8'h12, 1'b1, 1'b0);
        expect_frame(8'h12, 1'b1);
        step(20);
        compare_stream("post_reset");
        check("post_reset_byte", 32'(dut_byte), 32'h12);

`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'h0F;
`else
        glitch_exp = 8'h0F & ~8'h02;
`endif
        step(30);
        send_frame(8'h0F, 1'b1, 1'b1);
        expect_frame(glitch_exp, 1'b1);
        step(20);
        compare_stream("glitch");

        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, 1'b0);
            expect_frame(d, 1'b1);
            step($urandom_range(0, 30));
        end
        step(20);
        compare_stream("random");
        check("random_byte_held", 32'(dut_byte), 32'(last_good));
        check("final_fe_count", 32'(fe_count), 32'd1);
        check("final_busy", 32'(dut_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Serial-to-parallel UART receiver sitting directly upstream of the host command parser.
- Oversamples the asynchronous rx line, frames 8N1 characters and presents each received byte on a held `byte` bus with a one-cycle `byte_available` strobe.
- Flags framing errors and line breaks so the parser can resynchronise.

Parameters:
- CLOCK_FREQ, 50000000: clk frequency in Hz.
- BAUD_RATE, 115200: line rate in bits/s.
- OVERSAMPLE, 16: sample ticks per bit; must be even and at least 8.
- DIVISOR, CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE): clocks per sample tick; integer truncation; must be at least 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  raw serial line; idle high; asynchronous to clk.
- byte  output  8  last good received byte; held stable until the next good byte.
- byte_available  output  1  high for exactly one clk when `byte` is updated.
- frame_error  output  1  high for exactly one clk when the stop bit is sampled low.
- busy  output  1  high whenever the FSM is outside IDLE.

Behaviour:
- Reset (rst low, asynchronous): `byte`=0, `byte_available`=0, `frame_error`=0, `busy`=0; FSM to IDLE; all counters 0; synchroniser flops set to 1 (idle line).
- rx passes through a 2-flop synchroniser. All logic uses the synchronised value `rx_s`.
- Tick generator: counter 0..DIVISOR-1 produces a one-clk `tick` at the wrap. It is held at 0 in IDLE and restarted on start detection, so bit sampling is phase-aligned to the start edge.
- Bit sample point: tick index OVERSAMPLE/2 within each bit. `tick_cnt` counts 0..OVERSAMPLE-1 and wraps.
- IDLE:
  - `busy`=0.
  - A falling edge of `rx_s` (prev 1, now 0) moves to START, clears `tick_cnt`, `bit_cnt` and the divider.
- START:
  - At the sample point, if `rx_s`=1 the start is false (glitch): return to IDLE with no outputs.
  - Otherwise continue until the end of the start bit, then go to DATA.
- DATA:
  - Sample at each bit's sample point and shift LSB-first into an internal 8-bit shift register.
  - `bit_cnt` counts 0..7. After bit 7 finishes, go to STOP.
- STOP, at the sample point:
  - `rx_s`=1: on the next clk edge, `byte` ← shift register and `byte_available` pulses for 1 clk. Go to IDLE immediately (do not wait for the end of the stop bit), so back-to-back characters are caught.
  - `rx_s`=0: `frame_error` pulses for 1 clk; `byte` is unchanged; go to BREAK_WAIT.
- BREAK_WAIT: remain until `rx_s`=1, then go to IDLE. A held-low line (break) produces exactly one `frame_error` and no bytes.
- Guaranteed spacing: consecutive `byte_available` pulses are separated by at least one low clk, as the downstream parser requires edge detection.
- `byte_available` and `frame_error` are never high in the same cycle.
- Latency: from the rx stop-bit midpoint to the `byte_available` rising edge is 3 clks plus tick quantisation (2 synchroniser stages + 1 output register).
- Reset asserted mid-frame aborts the character. After release, the FSM waits in IDLE for a fresh falling edge; a partial frame in progress is ignored until the line returns high and falls again.
- State encoding: IDLE=0, START=1, DATA=2, STOP=3, BREAK_WAIT=4. Unused codes go to IDLE.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value (start, data, stop) is the 2-of-3 majority of `rx_s` at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The decision is taken at the third sample, so `byte_available` latency grows by one tick.
- Undefined: a single sample at tick OVERSAMPLE/2; no majority logic is instantiated.

Test Plan:
- CLOCK_FREQ=1600000, BAUD_RATE=10000 (DIVISOR=10, 160 clk/bit); send 0x4C -> `byte`=0x4C, exactly one `byte_available` pulse; `busy` low again before the next start bit.
- Send "L00000001" back-to-back with no idle gap -> 9 pulses; `byte` sequence 0x4C,0x30,...,0x31; no `frame_error`.
- rx low for 40 clk, then high -> false start; no `byte_available`, no `frame_error`; `busy` returns to 0.
- Send 0x55 with the stop bit forced low, then the line held low for 3000 clk -> one `frame_error` pulse; `byte` retains its previous value; next frame 0xA3 is received correctly.
- Assert rst low during data bit 4 of 0xFF, release, send 0x12 -> outputs 0 during reset; only 0x12 is reported.
- With UART_RX_MAJORITY_EN: send 0x0F with a 1-clk low glitch on rx at the midpoint of bit 1 -> `byte`=0x0F. Without the macro, the same glitch yields `byte`=0x0D.
